ahb_cmd_manager: RTL
====================

# ahb_cmd_manager

AHB-Lite manager that turns a simple valid/ready command stream into single-word AHB transfers on the hclk bus and returns read data and error status on a response stream. It is the initiating end for the GNSS register satellites, whose clock-domain-crossing handshake stretches `hready` for many cycles. It supports one pipelined overlap, where the next address phase runs during the current data phase. It handles two-cycle ERROR responses and flags a hung bus.

## Interface
- `TIMEOUT_CYCLES`, default 1024: number of consecutive wait-state cycles in one data phase before `bus_hang` sets.
- `hclk  in  1`: bus clock. All logic is in this domain.
- `nrst  in  1`: reset, synchronous, active-low.
- `cmd_valid  in  1` / `cmd_ready  out  1`: command handshake.
- `cmd_write  in  1`, `cmd_addr  in  32`, `cmd_wdata  in  32`: command payload.
- `rsp_valid  out  1` / `rsp_ready  in  1`: response handshake.
- `rsp_rdata  out  32`: read data; 0 for writes.
- `rsp_err  out  1`: transfer ended with an ERROR response.
- `haddr  out  32`, `htrans  out  htrans_t`, `hwrite  out  1`, `hsize  out  2`, `hburst  out  3`, `hwdata  out  32`: AHB manager outputs, all registered.
- `hready  in  1`, `hresp  in  1`, `hrdata  in  32`: from the bus mux.
- `hang_clr  in  1`: clears `bus_hang`.
- `bus_hang  out  1`: sticky timeout flag.

## Operation
- Pipeline stages:
  - A (address phase): `a_valid` plus the stored command.
  - D (data phase): `d_valid`, `d_write`, `d_wdata`.
  - R: 2-entry response FIFO.
- In-flight count = `a_valid` + `d_valid` + R occupancy. It never exceeds 2.
- `cmd_ready` = (in-flight < 2) && !(`a_valid` && !`hready`) && !`err_cycle2` && `nrst`.
- A command accepted loads A. For the following cycles, while A holds it:
  - `htrans`=NONSEQ, `haddr`/`hwrite` = command values.
  - `hsize`=HSIZE_WORD (2'b10), `hburst`=HBURST_SINGLE (3'b000).
- A→D: at a rising edge with `a_valid` && `hready` && !(`d_valid` && `hresp`). `htrans` drops to IDLE unless a new command loads A on the same edge.
- `hwdata` = `d_wdata` throughout the data phase. It holds its last value otherwise.
- D completes at an edge with `d_valid` && `hready`. The response is pushed into R:
  - `rsp_rdata` = `hrdata` for reads, 0 for writes.
  - `rsp_err` = `hresp`.
- R pops on `rsp_valid` && `rsp_ready`. `rsp_valid` = R non-empty. R pops in FIFO order.
- ERROR, first cycle (edge with `d_valid` && `hresp` && !`hready`):
  - Set `err_cycle2`.
  - Drive `htrans`=IDLE next cycle.
  - Any command in A is retained, not cancelled from the stream.
- ERROR, second cycle (`hready`=1): D completes with `rsp_err`=1 and `err_cycle2` clears. A retained command is re-driven as NONSEQ on the following cycle.
- Watchdog counter:
  - Counts cycles with `d_valid` && !`hready`, saturating at `TIMEOUT_CYCLES`.
  - Clears on D completion.
  - Reaching `TIMEOUT_CYCLES` sets `bus_hang`.
  - The transfer is never abandoned; the manager keeps waiting.
- `hang_clr` clears `bus_hang` and the counter. A simultaneous set wins.
- State summary:
  - IDLE: A, D and R empty.
  - ADDR: A only.
  - PIPE: A and D.
  - DATA: D only.
  - ERR2: `err_cycle2`.
  - R is orthogonal to these states.

## Timing
- Reset values:
  - `htrans`=IDLE; `haddr`, `hwdata`, `rsp_rdata` = 0.
  - `hwrite`, `rsp_valid`, `rsp_err`, `bus_hang` = 0.
  - `hsize`=2'b10, `hburst`=0.
  - A, D, R, counter and `err_cycle2` cleared.
- Reset mid-transfer abandons all in-flight state. No response is produced.
- Latency with zero wait states: command accepted at edge N, `haddr` valid N+1..N+2, data phase N+2..N+3, `rsp_valid`=1 from N+3. That is 3 cycles.
- Back-to-back commands with zero wait states and `rsp_ready`=1: one NONSEQ every cycle is allowed while in-flight < 2. Sustained throughput is 1 transfer per 2 cycles, set by the in-flight limit.
- Wait states extend the data phase. A held in PIPE keeps `haddr`/`htrans` stable, as AHB requires.
- R full (2 entries) with `rsp_ready`=0: `cmd_ready`=0, and D cannot exist because of the in-flight limit. The bus is never stalled by the response side.
- Push and pop on the same edge with R full is legal.

## Structure
- Use `htrans_t` from `common_types_pkg`.
- Add `HSIZE_WORD` and `HBURST_SINGLE` constants to `common_types_pkg`.
- Response FIFO is a sub-module, `sync_fifo_2` (2 entries, 33 bits wide, push/pop/full/empty).

## Test plan
- Write 0x2004_0404 ← 0x0DA3_C00A, zero-wait bus:
  - One NONSEQ cycle with `hwrite`=1.
  - `hwdata`=0x0DA3_C00A in the next cycle.
  - `rsp_valid` at +3 with `rsp_err`=0 and `rsp_rdata`=0.
- Read 0x2004_0100 from a model holding `hready`=0 for 8 data-phase cycles, `hrdata`=0x2: `rsp_rdata`=0x2 one cycle after `hready` rises. `haddr` stays stable throughout.
- Two reads issued back-to-back: the second NONSEQ overlaps the first data phase. Responses arrive in order with correct data.
- Write answered with an ERROR, second read pending in A:
  - `htrans`=IDLE in the second ERROR cycle.
  - Write response has `rsp_err`=1.
  - The read is re-issued and completes with `rsp_err`=0.
- `rsp_ready`=0 for 20 cycles with 4 commands offered: at most 2 transfers are accepted, `cmd_ready`=0 afterwards, and all 4 responses arrive in order after release.
- `TIMEOUT_CYCLES`=16, bus stuck at `hready`=0: `bus_hang`=1 after 16 wait cycles. `hang_clr` clears it. Asserting `nrst`=0 mid-stall returns every output to its reset value the next cycle.

Source files
------------

// File: rtl/common_types_pkg.sv
// common_types_pkg: shared AHB-Lite bus types and encodings.
package common_types_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    localparam logic [1:0] HSIZE_WORD    = 2'b10;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;

endpackage

// File: rtl/sync_fifo_2.sv
// sync_fifo_2: two-entry synchronous FIFO; push and pop may share an edge even when full.
module sync_fifo_2 #(
    parameter int W = 33
) (
    input  logic         hclk,
    input  logic         nrst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    logic [W-1:0] mem [2];
    logic         wp, rp, do_push, do_pop;
    logic [1:0]   cnt;

    assign full    = cnt == 2'd2;
    assign empty   = cnt == 2'd0;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rp];

    always_ff @(posedge hclk) begin
        if (!nrst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wp     <= 1'b0;
            rp     <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (do_push) mem[wp] <= din;
            wp  <= wp ^ do_push;
            rp  <= rp ^ do_pop;
            cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
        end
    end
endmodule

// File: rtl/ahb_cmd_manager.sv
// ahb_cmd_manager: valid/ready command stream to single-word AHB-Lite transfers, with one
// pipelined overlap, two-cycle ERROR handling and a sticky hung-bus watchdog.
module ahb_cmd_manager
    import common_types_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        hclk,
    input  logic        nrst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] haddr,
    output htrans_t     htrans,
    output logic        hwrite,
    output logic [1:0]  hsize,
    output logic [2:0]  hburst,
    output logic [31:0] hwdata,
    input  logic        hready,
    input  logic        hresp,
    input  logic [31:0] hrdata,
    input  logic        hang_clr,
    output logic        bus_hang
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic          a_valid, d_valid, d_write, err_cycle2;
    logic [31:0]   a_wdata;
    logic [CW-1:0] wd_cnt;
    logic          fifo_full, fifo_empty;
    logic [1:0]    r_occ;
    logic [2:0]    inflight;
    logic          load, adv, done, err1, a_next, wait_cyc, hang_set;

    assign hsize    = HSIZE_WORD;
    assign hburst   = HBURST_SINGLE;
    assign r_occ    = fifo_full ? 2'd2 : fifo_empty ? 2'd0 : 2'd1;
    assign inflight = {2'b0, a_valid} + {2'b0, d_valid} + {1'b0, r_occ};
    assign cmd_ready = inflight < 3'd2 && !(a_valid && !hready) && !err_cycle2 && nrst;
    assign load     = cmd_valid && cmd_ready;
    // An ERROR response holds the pending address phase back until it has fully resolved.
    assign adv      = a_valid && hready && !(d_valid && hresp);
    assign done     = d_valid && hready;
    assign err1     = d_valid && hresp && !hready;
    assign a_next   = load || (a_valid && !adv);
    assign wait_cyc = d_valid && !hready;
    assign hang_set = wait_cyc && wd_cnt == CW'(TIMEOUT_CYCLES - 1);
    assign rsp_valid = !fifo_empty;

    always_ff @(posedge hclk) begin
        if (!nrst) begin
            a_valid    <= 1'b0;
            d_valid    <= 1'b0;
            d_write    <= 1'b0;
            err_cycle2 <= 1'b0;
            a_wdata    <= '0;
            haddr      <= '0;
            hwrite     <= 1'b0;
            hwdata     <= '0;
            htrans     <= HTRANS_IDLE;
            wd_cnt     <= '0;
            bus_hang   <= 1'b0;
        end else begin
            a_valid <= a_next;
            if (load) begin
                haddr   <= cmd_addr;
                hwrite  <= cmd_write;
                a_wdata <= cmd_wdata;
            end
            // A retained command goes back to NONSEQ once the second ERROR cycle is over.
            htrans <= (a_next && !err1) ? HTRANS_NONSEQ : HTRANS_IDLE;
            if (adv) begin
                d_write <= hwrite;
                hwdata  <= a_wdata;
            end
            d_valid    <= adv || (d_valid && !hready);
            err_cycle2 <= err1 || (err_cycle2 && !done);
            wd_cnt     <= (done || hang_clr) ? '0 :
                          (wait_cyc && wd_cnt != CW'(TIMEOUT_CYCLES)) ? wd_cnt + 1'b1 : wd_cnt;
            bus_hang   <= hang_set || (bus_hang && !hang_clr);
        end
    end

    sync_fifo_2 #(.W(33)) u_rsp_fifo (
        .hclk  (hclk),
        .nrst  (nrst),
        .push  (done),
        .pop   (rsp_valid && rsp_ready),
        .din   ({hresp, d_write ? 32'h0 : hrdata}),
        .dout  ({rsp_err, rsp_rdata}),
        .full  (fifo_full),
        .empty (fifo_empty)
    );
endmodule
